// File: rtl/pattern_sequencer_pkg.sv
// Shared types and constants for the pattern sequencer and its serializer hookup.
package pattern_sequencer_pkg;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StLoad     = 3'd1,
      StStart    = 3'd2,
      StWaitDone = 3'd3,
      StGap      = 3'd4
   } seq_state_e;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_REPEAT  = 1'b1;
   localparam logic FREQ_LOW     = 1'b0;
   localparam logic FREQ_HIGH    = 1'b1;

   // Bits needed to count 0 .. n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Host write port plus serializer control bundle; master is the sequencer side.
interface pattern_sequencer_if #(
   parameter int unsigned DATA_BIT = 32
) ();

   logic                i_wr_valid;
   logic                o_wr_ready;
   logic [DATA_BIT-1:0] i_wr_data;
   logic                i_wr_freq;
   logic                i_ser_done_tick;
   logic                o_ser_start;
   logic                o_ser_stop;
   logic                o_ser_mode;
   logic                o_ser_sel_freq;
   logic [DATA_BIT-1:0] o_ser_data;

   modport master (
      input  i_wr_valid, i_wr_data, i_wr_freq, i_ser_done_tick,
      output o_wr_ready, o_ser_start, o_ser_stop, o_ser_mode, o_ser_sel_freq, o_ser_data
   );

   modport slave (
      output i_wr_valid, i_wr_data, i_wr_freq, i_ser_done_tick,
      input  o_wr_ready, o_ser_start, o_ser_stop, o_ser_mode, o_ser_sel_freq, o_ser_data
   );

endinterface

// File: rtl/pattern_sequencer_sync_fifo.sv
// Power-of-two synchronous FIFO with registered read data and a synchronous flush.
module pattern_sequencer_sync_fifo #(
   parameter  int unsigned WIDTH = 33,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = rdata_q;

   // Full blocks a push even when a pop lands in the same cycle.
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      rdata_d = rdata_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + AW'(1);
         if (do_pop) begin
            rptr_d  = rptr_q + AW'(1);
            rdata_d = mem_q[rptr_q];
         end
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         rdata_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: rtl/pattern_sequencer.sv
// Plays FIFO-buffered words into the variable-frequency serializer, one start per word,
// with inter-word gap, done-tick timeout and abort/flush.
module pattern_sequencer
   import pattern_sequencer_pkg::*;
#(
   parameter int unsigned DATA_BIT       = 32,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned GAP_CYCLES     = 0,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_run,
   input  logic                        i_abort,
   pattern_sequencer_if.master         bus,
   output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
   output logic                        o_busy,
   output logic                        o_word_done,
   output logic                        o_error
);

   localparam int unsigned TmoW = cnt_width(TIMEOUT_CYCLES);
   localparam int unsigned GapW = cnt_width(GAP_CYCLES);

   seq_state_e          state_q, state_d;
   logic [TmoW-1:0]     timer_q, timer_d;
   logic [GapW-1:0]     gap_q, gap_d;
   logic                error_q, error_d;
   logic                stop_q, stop_d;
   logic [DATA_BIT-1:0] data_q, data_d;
   logic                freq_q, freq_d;
   logic                rst_done_q;

   logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [DATA_BIT:0]   fifo_rdata;
   logic                timeout_fire;

   assign fifo_push = bus.i_wr_valid && bus.o_wr_ready && !i_abort;

   pattern_sequencer_sync_fifo #(
      .WIDTH (DATA_BIT + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (i_abort),
      .push_i  (fifo_push),
      .wdata_i ({bus.i_wr_freq, bus.i_wr_data}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (o_fifo_count)
   );

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      gap_d        = gap_q;
      error_d      = error_q;
      stop_d       = 1'b0;
      data_d       = data_q;
      freq_d       = freq_q;
      fifo_pop     = 1'b0;
      o_word_done  = 1'b0;
      timeout_fire = 1'b0;
      if (i_abort) begin
         // Serializer only needs stopping if a word may be in flight.
         stop_d  = (state_q != StIdle);
         error_d = 1'b0;
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (i_run && !fifo_empty) begin
                  fifo_pop = 1'b1;
                  state_d  = StLoad;
               end
            end
            StLoad: begin
               {freq_d, data_d} = fifo_rdata;
               state_d          = StStart;
            end
            StStart: begin
               timer_d = '0;
               state_d = StWaitDone;
            end
            StWaitDone: begin
               if (bus.i_ser_done_tick) begin
                  o_word_done = 1'b1;
                  gap_d       = '0;
                  state_d     = (GAP_CYCLES > 0) ? StGap : StIdle;
               end else if ((TIMEOUT_CYCLES != 0) &&
                            (timer_q == TmoW'(TIMEOUT_CYCLES - 1))) begin
                  timeout_fire = 1'b1;
                  error_d      = 1'b1;
                  state_d      = StIdle;
               end else begin
                  timer_d = timer_q + TmoW'(1);
               end
            end
            StGap: begin
               if (gap_q == GapW'(GAP_CYCLES - 1)) state_d = StIdle;
               else                                gap_d   = gap_q + GapW'(1);
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         gap_q      <= '0;
         error_q    <= 1'b0;
         stop_q     <= 1'b0;
         data_q     <= '0;
         freq_q     <= FREQ_LOW;
         rst_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         gap_q      <= gap_d;
         error_q    <= error_d;
         stop_q     <= stop_d;
         data_q     <= data_d;
         freq_q     <= freq_d;
         rst_done_q <= 1'b1;
      end
   end

   // Timeout stop and error appear in the expiry cycle; abort stop is the cycle after.
   assign bus.o_ser_stop     = stop_q | timeout_fire;
   assign o_error            = error_q | timeout_fire;
   assign bus.o_ser_start    = (state_q == StStart);
   assign bus.o_ser_mode     = MODE_ONESHOT;
   assign bus.o_ser_sel_freq = freq_q;
   assign bus.o_ser_data     = data_q;
   assign bus.o_wr_ready     = rst_done_q && !fifo_full;
   assign o_busy             = (state_q != StIdle);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench: push table, playback order/spacing, timeout, abort, run-drop and reset.
module tb_pattern_sequencer;

   localparam int unsigned DW = 32;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       abort = 1'b0;
   logic [2:0] fifo_count;
   logic       busy, word_done, error;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   pattern_sequencer_if #(.DATA_BIT(DW)) bus ();

   pattern_sequencer #(
      .DATA_BIT       (DW),
      .FIFO_DEPTH     (4),
      .GAP_CYCLES     (8),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_run        (run),
      .i_abort      (abort),
      .bus          (bus),
      .o_fifo_count (fifo_count),
      .o_busy       (busy),
      .o_word_done  (word_done),
      .o_error      (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          freq;
      logic          exp_ready;
      int            exp_count;
   } vec_t;

   vec_t vec [5];

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [DW-1:0] d, input logic f);
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = d;
      bus.i_wr_freq  = f;
      step();
      bus.i_wr_valid = 1'b0;
   endtask

   task automatic wait_start(input string name, output int at);
      int n = 0;
      while (!bus.o_ser_start && n < 300) begin
         step();
         n++;
      end
      checks++;
      if (!bus.o_ser_start) begin
         errors++;
         $display("FAIL %s: no start pulse within 300 cycles, got 0, want 1", name);
      end
      at = cyc;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         step();
         n++;
      end
      chk("wait_idle", {63'd0, busy}, 64'd0);
   endtask

   task automatic done_pulse(input string name, output int at);
      bus.i_ser_done_tick = 1'b1;
      #1;
      chk(name, {63'd0, word_done}, 64'd1);
      at = cyc;
      step();
      bus.i_ser_done_tick = 1'b0;
   endtask

   initial begin
      int s, d, prev_d, ns;

      vec[0] = '{32'h1111_0001, 1'b0, 1'b1, 1};
      vec[1] = '{32'h2222_0002, 1'b1, 1'b1, 2};
      vec[2] = '{32'h3333_0003, 1'b0, 1'b1, 3};
      vec[3] = '{32'h4444_0004, 1'b1, 1'b1, 4};
      vec[4] = '{32'h5555_0005, 1'b1, 1'b0, 4};

      bus.i_wr_valid      = 1'b0;
      bus.i_wr_data       = '0;
      bus.i_wr_freq       = 1'b0;
      bus.i_ser_done_tick = 1'b0;

      // Reset state
      repeat (3) step();
      chk("rst_ready", {63'd0, bus.o_wr_ready}, 64'd0);
      chk("rst_outs", {58'd0, bus.o_ser_start, bus.o_ser_stop, bus.o_ser_mode, busy, error,
                       word_done}, 64'd0);
      chk("rst_count", {61'd0, fifo_count}, 64'd0);
      rst_n = 1'b1;
      chk("rel_ready_early", {63'd0, bus.o_wr_ready}, 64'd0);
      step();
      chk("rel_ready", {63'd0, bus.o_wr_ready}, 64'd1);

      // Single word: start two cycles after IDLE sees run with a non-empty FIFO
      push(32'hA5A5_0F0F, 1'b1);
      chk("single_count", {61'd0, fifo_count}, 64'd1);
      run = 1'b1;
      chk("single_idle_busy", {63'd0, busy}, 64'd0);
      step();
      chk("single_load_nostart", {63'd0, bus.o_ser_start}, 64'd0);
      step();
      chk("single_start", {63'd0, bus.o_ser_start}, 64'd1);
      chk("single_data", {32'd0, bus.o_ser_data}, 64'hA5A5_0F0F);
      chk("single_freq", {63'd0, bus.o_ser_sel_freq}, 64'd1);
      repeat (30) step();
      chk("single_wait_busy", {63'd0, busy}, 64'd1);
      done_pulse("single_word_done", d);
      chk("single_done_once", {63'd0, word_done}, 64'd0);
      repeat (7) step();
      chk("single_gap_busy", {63'd0, busy}, 64'd1);
      step();
      chk("single_idle_after_gap", {63'd0, busy}, 64'd0);
      chk("single_no_error", {63'd0, error}, 64'd0);

      // Fill from the table; the fifth push meets a full FIFO
      run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.i_wr_valid = 1'b1;
         bus.i_wr_data  = vec[i].data;
         bus.i_wr_freq  = vec[i].freq;
         #1;
         chk($sformatf("fill_ready[%0d]", i), {63'd0, bus.o_wr_ready}, {63'd0, vec[i].exp_ready});
         step();
         chk($sformatf("fill_count[%0d]", i), {61'd0, fifo_count}, 64'(vec[i].exp_count));
      end
      bus.i_wr_valid = 1'b0;

      // Playback order and start spacing (done + GAP + 3)
      run = 1'b1;
      prev_d = 0;
      for (int i = 0; i < 4; i++) begin
         wait_start($sformatf("play_start[%0d]", i), s);
         chk($sformatf("play_data[%0d]", i), {32'd0, bus.o_ser_data}, {32'd0, vec[i].data});
         chk($sformatf("play_freq[%0d]", i), {63'd0, bus.o_ser_sel_freq}, {63'd0, vec[i].freq});
         if (i > 0) chk($sformatf("play_spacing[%0d]", i), 64'(s - prev_d), 64'd11);
         repeat (5) step();
         done_pulse($sformatf("play_done[%0d]", i), prev_d);
      end
      ns = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.o_ser_start) ns++;
         step();
      end
      chk("play_no_fifth", 64'(ns), 64'd0);
      chk("play_empty", {61'd0, fifo_count}, 64'd0);

      // Timeout: stop and error 50 cycles after start, next word still plays
      run = 1'b0;
      wait_idle();
      push(32'hCAFE_0001, 1'b0);
      push(32'hCAFE_0002, 1'b1);
      run = 1'b1;
      wait_start("tmo_start", s);
      repeat (49) step();
      chk("tmo_stop_early", {62'd0, bus.o_ser_stop, error}, 64'd0);
      step();
      chk("tmo_stop", {63'd0, bus.o_ser_stop}, 64'd1);
      chk("tmo_error", {63'd0, error}, 64'd1);
      chk("tmo_no_done", {63'd0, word_done}, 64'd0);
      step();
      chk("tmo_stop_one", {63'd0, bus.o_ser_stop}, 64'd0);
      chk("tmo_error_sticky", {63'd0, error}, 64'd1);
      wait_start("tmo_next_start", d);
      chk("tmo_next_latency", 64'(d - s), 64'd53);
      chk("tmo_next_data", {32'd0, bus.o_ser_data}, 64'hCAFE_0002);
      repeat (5) step();
      done_pulse("tmo_next_done", d);
      chk("tmo_error_kept", {63'd0, error}, 64'd1);

      // Abort in WAIT_DONE with three queued; push and done in that cycle are dropped
      run = 1'b0;
      wait_idle();
      for (int i = 0; i < 4; i++) push(vec[i].data, vec[i].freq);
      run = 1'b1;
      wait_start("abort_start", s);
      chk("abort_queued", {61'd0, fifo_count}, 64'd3);
      repeat (3) step();
      abort               = 1'b1;
      bus.i_wr_valid      = 1'b1;
      bus.i_wr_data       = 32'hDEAD_BEEF;
      bus.i_ser_done_tick = 1'b1;
      #1;
      chk("abort_no_word_done", {63'd0, word_done}, 64'd0);
      step();
      abort               = 1'b0;
      bus.i_wr_valid      = 1'b0;
      bus.i_ser_done_tick = 1'b0;
      chk("abort_stop", {63'd0, bus.o_ser_stop}, 64'd1);
      chk("abort_count", {61'd0, fifo_count}, 64'd0);
      chk("abort_error_clr", {63'd0, error}, 64'd0);
      chk("abort_idle", {63'd0, busy}, 64'd0);
      step();
      chk("abort_stop_one", {62'd0, bus.o_ser_stop, bus.o_ser_start}, 64'd0);

      // Done tick in the timeout cycle wins
      push(32'hBEEF_0001, 1'b0);
      wait_start("race_start", s);
      repeat (50) step();
      bus.i_ser_done_tick = 1'b1;
      #1;
      chk("race_word_done", {63'd0, word_done}, 64'd1);
      chk("race_no_stop", {62'd0, bus.o_ser_stop, error}, 64'd0);
      step();
      bus.i_ser_done_tick = 1'b0;
      chk("race_no_error", {63'd0, error}, 64'd0);

      // i_run dropped mid-word: word completes, no new start until run rises
      run = 1'b0;
      wait_idle();
      push(32'h0000_00A1, 1'b1);
      push(32'h0000_00A2, 1'b0);
      run = 1'b1;
      wait_start("runlow_start", s);
      run = 1'b0;
      repeat (5) step();
      done_pulse("runlow_done", d);
      ns = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.o_ser_start) ns++;
         step();
      end
      chk("runlow_no_start", 64'(ns), 64'd0);
      chk("runlow_count", {61'd0, fifo_count}, 64'd1);
      run = 1'b1;
      wait_start("runlow_resume", s);
      chk("runlow_resume_data", {32'd0, bus.o_ser_data}, 64'h0000_00A2);

      // Reset mid-word drops the queued word and the word in flight
      push(32'h0000_00B1, 1'b1);
      step();
      rst_n = 1'b0;
      #1;
      chk("midrst_outs", {58'd0, bus.o_ser_start, bus.o_ser_stop, bus.o_ser_sel_freq, busy,
                          error, bus.o_wr_ready}, 64'd0);
      chk("midrst_data", {32'd0, bus.o_ser_data}, 64'd0);
      chk("midrst_count", {61'd0, fifo_count}, 64'd0);
      run = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("midrst_ready", {63'd0, bus.o_wr_ready}, 64'd1);
      chk("midrst_idle", {61'd0, fifo_count} | {63'd0, busy}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
      $fatal(1, "watchdog");
   end

endmodule
